// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: command decoder sitting behind an SPI slave. Accepts
// write-address / write-data / read-address / read-data commands and
// returns one byte per read with a fixed one-cycle latency.
module spi_ram_ctrl #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter bit AUTO_INC  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       seq_err
);

    localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    logic [7:0]           mem [0:MEM_DEPTH-1];
    state_t               state;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic                 wr_addr_vld;
    logic                 rd_addr_vld;
    logic [1:0]           cmd;
    logic [ADDR_SIZE-1:0] addr_in;
    logic                 addr_ok;
    logic                 mem_we;

    // Post-increment with wrap at the top of the populated memory range
    function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + ADDR_SIZE'(1);
    endfunction

    // Command field split, address range check and write strobe
    always_comb begin
        cmd     = rx_data[9:8];
        addr_in = ADDR_SIZE'(rx_data[7:0]);
        addr_ok = (32'(addr_in) < MEM_DEPTH);
        mem_we  = rx_valid && (cmd == 2'b01) && wr_addr_vld;
    end

    // Storage array: no reset so contents survive rst_n
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr[MEM_AW-1:0]] <= rx_data[7:0];
        end
    end

    // Command decode, address registers, response FSM and error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tx_data     <= '0;
            seq_err     <= 1'b0;
            wr_addr     <= '0;
            rd_addr     <= '0;
            wr_addr_vld <= 1'b0;
            rd_addr_vld <= 1'b0;
        end else begin
            state   <= IDLE;
            seq_err <= 1'b0;
            if (rx_valid) begin
                case (cmd)
                    2'b00: begin
                        if (addr_ok) begin
                            wr_addr     <= addr_in;
                            wr_addr_vld <= 1'b1;
                        end else begin
                            seq_err <= 1'b1;
                        end
                    end
                    2'b01: begin
                        if (wr_addr_vld) begin
                            if (AUTO_INC) wr_addr <= next_addr(wr_addr);
                        end else begin
                            seq_err <= 1'b1;
                        end
                    end
                    2'b10: begin
                        if (addr_ok) begin
                            rd_addr     <= addr_in;
                            rd_addr_vld <= 1'b1;
                        end else begin
                            seq_err <= 1'b1;
                        end
                    end
                    default: begin
                        if (rd_addr_vld) begin
                            state   <= RESP;
                            tx_data <= mem[rd_addr[MEM_AW-1:0]];
                            if (AUTO_INC) rd_addr <= next_addr(rd_addr);
                        end else begin
                            seq_err <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // Response strobe decoded straight from the state flop
    assign tx_valid = (state == RESP);

endmodule
